// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver (and the transmitter beside it).
// Optional even-parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clocks per oversample tick, rounded down.
    function automatic int calc_div(input int clk_rate, input int baud_rate, input int oversample);
        return clk_rate / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Serial line in, received byte and status out; master = receiver, slave = host side.
interface uart_rx_os_if;
    import uart_pkg::*;

    logic                      rx_i;
    logic [UART_DATA_BITS-1:0] data_o;
    logic                      datEn_o;
    logic                      frameErr_o;
    logic                      parityErr_o;
    logic                      busy_o;

    modport master (
        input  rx_i,
        output data_o, datEn_o, frameErr_o, parityErr_o, busy_o
    );

    modport slave (
        output rx_i,
        input  data_o, datEn_o, frameErr_o, parityErr_o, busy_o
    );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider: counts 0..DIV-1 and pulses tick on the last count.
// A synchronous clear restarts the phase; shared with the transmitter.
module uart_rx_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
// Bits are decided by 2-of-3 majority around mid-bit; the byte is strobed at the stop-bit decision.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_RATE   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_rx_os_if.master  bus
);
    localparam int DIV = calc_div(CLK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int IW  = $clog2(UART_DATA_BITS);

    logic sync1, sync2, prev;
    logic fall;
    logic tick, tick_clr;

    rx_state_t                 state, state_n;
    logic [SW-1:0]             s, s_n;
    logic [IW-1:0]             idx, idx_n;
    logic [UART_DATA_BITS-1:0] sh, sh_n;
    logic                      samp_a, samp_a_n, samp_b, samp_b_n;
    logic [UART_DATA_BITS-1:0] data_q, data_n;
    logic                      den_q, den_n;
    logic                      ferr_q, ferr_n;
    logic                      majority, decide, bit_end;
`ifdef UART_RX_PARITY_EN
    logic                      pmis_q, pmis_n;
    logic                      perr_q, perr_n;
`endif

    // Line synchronizer plus the previous-value register for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= bus.rx_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall = prev & ~sync2;

    uart_rx_tick_gen #(.DIV(DIV)) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign decide   = tick && (s == SW'(M + 1));
    assign bit_end  = tick && (s == SW'(OVERSAMPLE - 1));
    assign majority = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n  = state;
        s_n      = s;
        idx_n    = idx;
        sh_n     = sh;
        samp_a_n = samp_a;
        samp_b_n = samp_b;
        data_n   = data_q;
        den_n    = 1'b0;
        ferr_n   = ferr_q;
        tick_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
        pmis_n   = pmis_q;
        perr_n   = perr_q;
`endif

        if (tick) begin
            s_n = bit_end ? '0 : s + SW'(1);
            if (s == SW'(M - 1)) samp_a_n = sync2;
            if (s == SW'(M))     samp_b_n = sync2;
        end

        case (state)
            IDLE: begin
                s_n = '0;
                if (fall) begin
                    state_n  = START;
                    tick_clr = 1'b1;
                end
            end
            START: begin
                if (decide && majority) begin
                    state_n = IDLE;
                end else if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (decide) sh_n = {majority, sh[UART_DATA_BITS-1:1]};
                if (bit_end) begin
                    if (idx == IW'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide)  pmis_n  = majority ^ (^sh);
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                // Deliver at mid-stop so a back-to-back start bit is never missed.
                if (decide) begin
                    data_n  = sh;
                    ferr_n  = ~majority;
                    den_n   = 1'b1;
                    state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                    perr_n  = pmis_q;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            s      <= '0;
            idx    <= '0;
            sh     <= '0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
            data_q <= '0;
            den_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pmis_q <= 1'b0;
            perr_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            s      <= s_n;
            idx    <= idx_n;
            sh     <= sh_n;
            samp_a <= samp_a_n;
            samp_b <= samp_b_n;
            data_q <= data_n;
            den_q  <= den_n;
            ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
            pmis_q <= pmis_n;
            perr_q <= perr_n;
`endif
        end
    end

    assign bus.data_o     = data_q;
    assign bus.datEn_o    = den_q;
    assign bus.frameErr_o = ferr_q;
    assign bus.busy_o     = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parityErr_o = perr_q;
`else
    assign bus.parityErr_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed scenarios plus random frames, checked against a frame-level queue model.
// Honors UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int CLK_RATE = 16000;
    localparam int BAUD     = 100;
    localparam int OS       = 16;
    localparam int DIV      = 10;
    localparam int BIT      = OS * DIV;
    localparam int M        = OS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // rx_i drive to strobe: 3 sync cycles plus START-to-strobe (one cycle of slack allowed).
    localparam int LAT = 3 + (9 * OS + M + 2) * DIV + PAR_BITS * OS * DIV;

    typedef struct {
        logic [7:0] data;
        bit         ferr;
        bit         perr;
        int         t0;
    } frame_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    uart_rx_os_if bus();

    uart_rx_os #(
        .CLK_RATE   (CLK_RATE),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         strobes = 0;
    frame_t     exp_q[$];
    logic [7:0] exp_data = 8'h00;
    bit         exp_ferr = 1'b0;
    bit         exp_perr = 1'b0;
    bit         checking = 1'b0;
    bit         prev_busy = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives one frame and queues what the receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par);
        frame_t f;
        f.data = d;
        f.ferr = !stop;
`ifdef UART_RX_PARITY_EN
        f.perr = (par != ^d);
`else
        f.perr = 1'b0;
`endif
        f.t0 = cyc;
        exp_q.push_back(f);
        bus.rx_i = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = d[i];
            hold(BIT);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx_i = par;
        hold(BIT);
`endif
        bus.rx_i = stop;
        hold(BIT);
    endtask

    task automatic glitch(input int len);
        bus.rx_i = 1'b0;
        hold(len);
        bus.rx_i = 1'b1;
        hold(150);
    endtask

    // Compare process: every idle-of-reset cycle, the outputs must match the last delivered frame.
    always @(negedge clk_i) begin : compare
        frame_t f;
        if (checking && !rst_i) begin
            if (bus.datEn_o) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_strobe", 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    exp_data = f.data;
                    exp_ferr = f.ferr;
                    exp_perr = f.perr;
                    check((cyc - f.t0) >= LAT && (cyc - f.t0) <= LAT + 1, "strobe_latency", cyc - f.t0, LAT);
                    check(prev_busy && !bus.busy_o, "busy_fall_at_strobe", {prev_busy, bus.busy_o}, 2);
                end
            end
            check(bus.data_o == exp_data, "data_o", bus.data_o, exp_data);
            check(bus.frameErr_o == exp_ferr, "frameErr_o", bus.frameErr_o, exp_ferr);
            check(bus.parityErr_o == exp_perr, "parityErr_o", bus.parityErr_o, exp_perr);
            prev_busy = bus.busy_o;
        end
    end

    initial begin
        int         s0, first, nb, gap;
        logic [7:0] d;
        bit         stop, par;

        bus.rx_i = 1'b1;
        rst_i = 1'b1;
        hold(4);
        rst_i = 1'b0;
        @(negedge clk_i);
        check(bus.data_o == 8'h00, "reset_data", bus.data_o, 0);
        check(bus.datEn_o == 1'b0, "reset_datEn", bus.datEn_o, 0);
        check(bus.frameErr_o == 1'b0, "reset_frameErr", bus.frameErr_o, 0);
        check(bus.parityErr_o == 1'b0, "reset_parityErr", bus.parityErr_o, 0);
        check(bus.busy_o == 1'b0, "reset_busy", bus.busy_o, 0);
        checking = 1'b1;
        @(posedge clk_i);
        #1;

        // Clean 0x55.
        send_frame(8'h55, 1'b1, 1'b0);
        hold(200);
        check(strobes == 1, "strobes_after_55", strobes, 1);
        check(bus.data_o == 8'h55, "data_55", bus.data_o, 8'h55);
        check(bus.frameErr_o == 1'b0, "ferr_55", bus.frameErr_o, 0);

        // 0xA3 with a low stop bit, then the line stays low (break).
        send_frame(8'hA3, 1'b0, 1'b0);
        hold(480);
        bus.rx_i = 1'b1;
        hold(100);
        check(strobes == 2, "strobes_after_break", strobes, 2);
        check(bus.data_o == 8'hA3, "data_A3", bus.data_o, 8'hA3);
        check(bus.frameErr_o == 1'b1, "ferr_A3", bus.frameErr_o, 1);

        // 40-clk glitch: busy for exactly (M+2)*DIV cycles, no strobe.
        s0 = cyc;
        first = -1;
        nb = 0;
        bus.rx_i = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (cyc - s0 >= 40) bus.rx_i = 1'b1;
            if (bus.busy_o) begin
                nb++;
                if (first < 0) first = cyc - s0;
            end
        end
        @(posedge clk_i);
        #1;
        check(first == 3, "glitch_busy_rise", first, 3);
        check(nb == (M + 2) * DIV, "glitch_busy_len", nb, (M + 2) * DIV);
        check(strobes == 2, "glitch_no_strobe", strobes, 2);
        hold(100);
        send_frame(8'h81, 1'b1, 1'b0);
        hold(200);
        check(bus.data_o == 8'h81, "data_81", bus.data_o, 8'h81);

        // Back-to-back with no idle time.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        hold(200);
        check(strobes == 5, "strobes_b2b", strobes, 5);
        check(bus.data_o == 8'hFF, "data_FF", bus.data_o, 8'hFF);

        // Reset in the middle of data bit 4; that frame must vanish.
        d = 8'h5A;
        bus.rx_i = 1'b0;
        hold(BIT);
        for (int i = 0; i < 4; i++) begin
            bus.rx_i = d[i];
            hold(BIT);
        end
        bus.rx_i = d[4];
        hold(BIT / 2);
        bus.rx_i = 1'b1;
        rst_i = 1'b1;
        exp_q.delete();
        exp_data = 8'h00;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        hold(1);
        rst_i = 1'b0;
        @(negedge clk_i);
        check(bus.data_o == 8'h00, "rst_mid_data", bus.data_o, 0);
        check(bus.datEn_o == 1'b0, "rst_mid_datEn", bus.datEn_o, 0);
        check(bus.frameErr_o == 1'b0, "rst_mid_ferr", bus.frameErr_o, 0);
        check(bus.busy_o == 1'b0, "rst_mid_busy", bus.busy_o, 0);
        @(posedge clk_i);
        #1;
        hold(200);
        send_frame(8'h3C, 1'b1, 1'b0);
        hold(200);
        check(strobes == 6, "strobes_after_rst", strobes, 6);
        check(bus.data_o == 8'h3C, "data_3C", bus.data_o, 8'h3C);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        hold(200);
        check(bus.parityErr_o == 1'b1, "perr_07_bad", bus.parityErr_o, 1);
        send_frame(8'h07, 1'b1, 1'b1);
        hold(200);
        check(bus.parityErr_o == 1'b0, "perr_07_good", bus.parityErr_o, 0);
`endif

        // Random frames, occasional glitches, framing and parity errors.
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 4) == 0) glitch($urandom_range(2, 60));
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            par  = ($urandom_range(0, 3) == 0) ? !(^d) : ^d;
            send_frame(d, stop, par);
            gap = stop ? $urandom_range(0, 200) : $urandom_range(20, 200);
            bus.rx_i = 1'b1;
            if (gap > 0) hold(gap);
        end

        hold(300);
        check(exp_q.size() == 0, "pending_frames", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: the receive end for frames produced by the team's UART transmitter. It recovers 8N1 frames from an asynchronous serial line, or 8E1 frames when parity is compiled in. It uses 16x oversampling, majority-vote bit decisions, false-start rejection and framing/parity error flags. It sits beside the transmitter inside the UART top and presents each received byte as a one-cycle strobe to the host logic.

## Interface
- CLK_RATE, 100000000, system clock frequency in Hz
- BAUD_RATE, 9600, line bit rate in baud
- OVERSAMPLE, 16, sample ticks per bit; must be >= 8
- clk_i  input  1  system clock; the only clock
- rst_i  input  1  reset, synchronous, active-high
- rx_i  input  1  asynchronous serial line; idle high
- data_o  output  8  last received byte; held until the next frame completes
- datEn_o  output  1  one-cycle strobe; data_o and the error flags are valid in this cycle
- frameErr_o  output  1  stop bit sampled low for the last frame
- parityErr_o  output  1  parity mismatch for the last frame; constant 0 without parity
- busy_o  output  1  high whenever state != IDLE

## Operation
- Input path: 2-flop synchronizer, followed by one edge-detect register. All three reset to 1.
- Tick generator:
  - DIV = CLK_RATE/(BAUD_RATE*OVERSAMPLE), integer floor.
  - Counter runs 0..DIV-1 and pulses tick at DIV-1.
  - It is cleared on start detection, so the sample phase aligns to the falling edge.
- Sample counter s counts ticks 0..OVERSAMPLE-1 within a bit.
- Sampling points: s = M-1, M, M+1, with M = OVERSAMPLE/2. The bit value is the 2-of-3 majority, decided at tick s = M+1.
- State machine (package enum):
  - IDLE: on a falling edge of the synced line (prev=1, now=0) -> START; clear tick counter and s.
  - START: majority 1 at the decision point -> IDLE (false start, no strobe). At end of bit (s = OVERSAMPLE-1 tick) -> DATA with bit index 0.
  - DATA: shift in LSB first, one bit per decision. After the bit-7 period ends -> PARITY if compiled in, else STOP.
  - PARITY: at the decision point, compare against even parity of the 8 data bits. After the bit period -> STOP.
  - STOP: at the decision point:
    - register data_o from the shift register;
    - set frameErr_o = ~majority and parityErr_o = mismatch;
    - assert datEn_o for one cycle;
    - go to IDLE immediately, without waiting for the end of the stop bit, which allows back-to-back frames.
- Error flags persist until the next datEn_o.
- A frame with a framing error is still delivered.
- Break or stuck-low line: after a stop-bit framing error, IDLE requires the line to go high, then a new falling edge, before a new frame starts. There are no repeated strobes.
- Reset mid-frame: return to IDLE. Clear data_o, datEn_o, frameErr_o and parityErr_o to 0 and busy_o to 0. The partial frame is discarded.

## Timing
- Reset values: data_o=0x00, datEn_o=0, frameErr_o=0, parityErr_o=0, busy_o=0, state=IDLE.
- rx_i falling edge to START entry: 3 clk cycles (2 sync + edge register).
- START entry to datEn_o:
  - without parity: (9*OVERSAMPLE + M+2)*DIV + 1 cycles;
  - with parity: add OVERSAMPLE*DIV.
- datEn_o is high for exactly 1 cycle per accepted frame. It is never asserted for a false start.
- busy_o rises in the cycle START is entered and falls in the cycle datEn_o is asserted.
- False start: returns to IDLE at the START decision point, (M+2)*DIV cycles after entry.

## Configuration
- UART_RX_PARITY_EN defined: an even parity bit follows the data bits, and parityErr_o reports mismatch.
- UART_RX_PARITY_EN undefined: no PARITY state, parityErr_o is tied 0, and timing follows the 8N1 figures.

## Structure
- Package uart_pkg contains:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - UART_DATA_BITS = 8;
  - a function computing DIV from CLK_RATE, BAUD_RATE and OVERSAMPLE.
- Sub-module uart_rx_tick_gen: the DIV counter with a synchronous clear input and a tick output. It can be reused by the transmitter.

## Test plan
Bench parameters: CLK_RATE=16000, BAUD_RATE=100, OVERSAMPLE=16, giving DIV=10 and one bit = 160 clk.
- Send 0x55 in 8N1 with a good stop bit -> exactly one datEn_o, data_o=0x55, frameErr_o=0, parityErr_o=0.
- Send 0xA3 with the stop bit driven 0 -> data_o=0xA3, frameErr_o=1; no second frame until the line is high and then has a new falling edge.
- Drive a 40-clk low glitch on an idle line -> busy_o pulses, no datEn_o, state returns to IDLE, next byte 0x81 is received correctly.
- Send 0x00 then 0xFF back-to-back with zero idle time -> two strobes, data 0x00 then 0xFF, no errors.
- Assert rst_i for 1 cycle mid-way through bit 4 of a frame -> all outputs 0 next cycle, no strobe for that frame; a following 0x3C is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parityErr_o=1. Send 0x07 with parity bit 1 -> parityErr_o=0.
